eth_mii_tx: RTL and testbench

- MII transmit MAC back-end, directly downstream of the frame generator in fpga_core.
- Accepts 32-bit AXI-stream-style frame words (dst MAC onward; no preamble, no FCS).
- Serializes them to 4-bit MII nibbles, prepends preamble/SFD, zero-pads to minimum length, appends CRC-32 FCS, and enforces the inter-frame gap.
- Runs in the phy_tx_clk domain, 25 MHz for 100BASE-T.

---
 rtl/eth_pkg.sv | 30 +++
 rtl/eth_mii_tx_if.sv | 15 +
 rtl/eth_crc32_nibble.sv | 19 +
 rtl/eth_mii_tx.sv | 217 +++++++++++++++++++++
 tb/tb_eth_mii_tx.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the MII transmit path.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG,
        ST_DRAIN
    } tx_state_t;

    localparam logic [3:0]  ETH_PREAMBLE_NIB = 4'h5;
    localparam logic [3:0]  ETH_SFD_NIB      = 4'hD;
    localparam logic [31:0] CRC32_POLY_REFL  = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT       = 32'hFFFFFFFF;

    // Index of the final nibble of a word; keep of 0 counts as a full word.
    function automatic logic [2:0] last_nib_idx(input logic last, input logic [3:0] keep);
        if (!last) return 3'd7;
        case (keep)
            4'h1:    return 3'd1;
            4'h3:    return 3'd3;
            4'h7:    return 3'd5;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/eth_mii_tx_if.sv
// AXI-stream style frame word channel feeding the MII transmitter.
interface eth_mii_tx_if;

    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;

    modport master (output s_tdata, output s_tkeep, output s_tvalid, output s_tlast,
                    input  s_tready);
    modport slave  (input  s_tdata, input  s_tkeep, input  s_tvalid, input  s_tlast,
                    output s_tready);

endinterface

// File: rtl/eth_crc32_nibble.sv
// One 4-bit step of the reflected Ethernet CRC-32; purely combinational.
module eth_crc32_nibble
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nibble,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in ^ {28'd0, nibble};
        for (int i = 0; i < 4; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_mii_tx.sv
// MII transmit back-end: preamble/SFD, nibble serialisation, padding, FCS and IFG.
module eth_mii_tx
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_BYTES  = 60,
    parameter int IFG_NIBBLES      = 24,
    parameter int PREAMBLE_NIBBLES = 15
) (
    input  logic          clk,
    input  logic          rst,
    eth_mii_tx_if.slave   s_axis,
    output logic [3:0]    phy_txd,
    output logic          phy_tx_en,
    output logic          phy_tx_er,
    output logic          tx_busy,
    output logic          tx_frame_done,
    output logic          tx_underrun
);

    localparam logic [7:0]  PRE_LAST  = 8'(PREAMBLE_NIBBLES - 1);
    localparam logic [7:0]  SFD_IDX   = 8'(PREAMBLE_NIBBLES);
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_NIBBLES - 1);
    localparam logic [11:0] MIN_BYTES = 12'(MIN_FRAME_BYTES);

    tx_state_t   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        word_last_q, word_last_d;
    logic [2:0]  last_idx_q, last_idx_d;
    logic [11:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] crc_q, crc_d, crc_upd;
    logic [3:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d, tx_er_q, tx_er_d;
    logic        busy_q, done_q, done_d, underrun_q, underrun_d, tready_q, tready_d;

    logic        start_frame, load_word, go_underrun, go_fcs;
    logic [2:0]  nib_next;
    logic [11:0] byte_inc;

    // CRC absorbs the data/pad nibble currently on the wire.
    eth_crc32_nibble u_crc (
        .crc_in  (crc_q),
        .nibble  (txd_q),
        .crc_out (crc_upd)
    );

    assign nib_next = cnt_q[2:0] + 3'd1;
    assign byte_inc = (byte_cnt_q == 12'hFFF) ? byte_cnt_q : byte_cnt_q + 12'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        word_last_d = word_last_q;
        last_idx_d  = last_idx_q;
        byte_cnt_d  = byte_cnt_q;
        crc_d       = crc_q;
        txd_d       = 4'h0;
        tx_en_d     = 1'b0;
        tx_er_d     = 1'b0;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        tready_d    = 1'b0;
        start_frame = 1'b0;
        load_word   = 1'b0;
        go_underrun = 1'b0;
        go_fcs      = 1'b0;

        if (state_q == ST_DATA || state_q == ST_PAD) crc_d = crc_upd;

        unique case (state_q)
            ST_IDLE: start_frame = s_axis.s_tvalid;
            ST_PREAMBLE: begin
                if (cnt_q == SFD_IDX) begin
                    load_word   = s_axis.s_tvalid;
                    go_underrun = !s_axis.s_tvalid;
                end else begin
                    cnt_d    = cnt_q + 8'd1;
                    tx_en_d  = 1'b1;
                    txd_d    = (cnt_q == PRE_LAST) ? ETH_SFD_NIB : ETH_PREAMBLE_NIB;
                    tready_d = (cnt_q == PRE_LAST);
                end
            end
            ST_DATA: begin
                if (cnt_q[2:0] != last_idx_q) begin
                    cnt_d    = {5'd0, nib_next};
                    tx_en_d  = 1'b1;
                    txd_d    = word_q[{nib_next, 2'b00} +: 4];
                    tready_d = !word_last_q && (nib_next == 3'd7);
                    if (nib_next[0]) byte_cnt_d = byte_inc;
                end else if (!word_last_q) begin
                    load_word   = s_axis.s_tvalid;
                    go_underrun = !s_axis.s_tvalid;
                end else if (byte_cnt_q < MIN_BYTES) begin
                    state_d = ST_PAD;
                    cnt_d   = 8'd0;
                    tx_en_d = 1'b1;
                end else begin
                    go_fcs = 1'b1;
                end
            end
            ST_PAD: begin
                // Pad nibbles come in low/high pairs so the byte count stays whole.
                if (!cnt_q[0] || byte_cnt_q < MIN_BYTES) begin
                    cnt_d   = {7'd0, ~cnt_q[0]};
                    tx_en_d = 1'b1;
                    if (!cnt_q[0]) byte_cnt_d = byte_inc;
                end else begin
                    go_fcs = 1'b1;
                end
            end
            ST_FCS: begin
                if (cnt_q[2:0] != 3'd7) begin
                    cnt_d   = {5'd0, nib_next};
                    tx_en_d = 1'b1;
                    txd_d   = ~crc_q[{nib_next, 2'b00} +: 4];
                    done_d  = (nib_next == 3'd7);
                end else begin
                    state_d = ST_IFG;
                    cnt_d   = 8'd0;
                end
            end
            ST_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d     = ST_IDLE;
                    start_frame = s_axis.s_tvalid;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (s_axis.s_tvalid && s_axis.s_tlast) begin
                    state_d = ST_IFG;
                    cnt_d   = 8'd0;
                end else begin
                    tready_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_frame) begin
            state_d    = ST_PREAMBLE;
            cnt_d      = 8'd0;
            tx_en_d    = 1'b1;
            txd_d      = ETH_PREAMBLE_NIB;
            crc_d      = CRC32_INIT;
            byte_cnt_d = 12'd0;
        end
        if (load_word) begin
            state_d     = ST_DATA;
            cnt_d       = 8'd0;
            word_d      = s_axis.s_tdata;
            word_last_d = s_axis.s_tlast;
            last_idx_d  = last_nib_idx(s_axis.s_tlast, s_axis.s_tkeep);
            tx_en_d     = 1'b1;
            txd_d       = s_axis.s_tdata[3:0];
        end
        // First FCS nibble must use the CRC including the nibble now on the wire.
        if (go_fcs) begin
            state_d = ST_FCS;
            cnt_d   = 8'd0;
            tx_en_d = 1'b1;
            txd_d   = ~crc_upd[3:0];
        end
        if (go_underrun) begin
            state_d    = ST_DRAIN;
            tx_en_d    = 1'b1;
            tx_er_d    = 1'b1;
            underrun_d = 1'b1;
            tready_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            word_q      <= 32'd0;
            word_last_q <= 1'b0;
            last_idx_q  <= 3'd0;
            byte_cnt_q  <= 12'd0;
            crc_q       <= CRC32_INIT;
            txd_q       <= 4'h0;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            word_last_q <= word_last_d;
            last_idx_q  <= last_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            crc_q       <= crc_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            busy_q      <= (state_d != ST_IDLE);
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            tready_q    <= tready_d;
        end
    end

    assign s_axis.s_tready = tready_q;
    assign phy_txd         = txd_q;
    assign phy_tx_en       = tx_en_q;
    assign phy_tx_er       = tx_er_q;
    assign tx_busy         = busy_q;
    assign tx_frame_done   = done_q;
    assign tx_underrun     = underrun_q;

endmodule

// File: tb/tb_eth_mii_tx.sv
// Scoreboard bench for eth_mii_tx: a byte-level frame model predicts every MII nibble.
module tb_eth_mii_tx;

    localparam int MIN_BYTES = 60;
    localparam int IFG       = 24;
    localparam int PRE       = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #20 clk = ~clk;

    eth_mii_tx_if axis ();

    logic [3:0] phy_txd;
    logic       phy_tx_en, phy_tx_er, tx_busy, tx_frame_done, tx_underrun;

    eth_mii_tx #(
        .MIN_FRAME_BYTES  (MIN_BYTES),
        .IFG_NIBBLES      (IFG),
        .PREAMBLE_NIBBLES (PRE)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis        (axis),
        .phy_txd       (phy_txd),
        .phy_tx_en     (phy_tx_en),
        .phy_tx_er     (phy_tx_er),
        .tx_busy       (tx_busy),
        .tx_frame_done (tx_frame_done),
        .tx_underrun   (tx_underrun)
    );

    int checks = 0;
    int errors = 0;

    // Expected nibble entries: {txd, tx_er, frame_done, underrun}
    logic [6:0] exp_q[$];
    int         len_q[$];
    int         gap_q[$];
    bit         mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32_bytes(input logic [7:0] b[$]);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i]) begin
            c = c ^ {24'd0, b[i]};
            repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Reference model: builds the whole wire image of a frame from its bytes.
    task automatic push_frame(input logic [31:0] w[$], input logic [3:0] kp, input int miss);
        logic [7:0]  b[$];
        logic [31:0] wv, fcs;
        logic [7:0]  v;
        int          n, nb;
        n = w.size();
        for (int i = 0; i < PRE; i++) exp_q.push_back({4'h5, 3'b000});
        exp_q.push_back({4'hD, 3'b000});
        if (miss >= 0) begin
            for (int i = 0; i < miss; i++) begin
                wv = w[i];
                for (int j = 0; j < 8; j++) exp_q.push_back({wv[4*j +: 4], 3'b000});
            end
            exp_q.push_back({4'h0, 3'b101});
            len_q.push_back(PRE + 1 + 8 * miss + 1);
            gap_q.push_back(n - miss - 1 + IFG);
        end else begin
            nb = (kp == 4'h1) ? 1 : (kp == 4'h3) ? 2 : (kp == 4'h7) ? 3 : 4;
            for (int i = 0; i < n; i++) begin
                wv = w[i];
                for (int j = 0; j < ((i == n - 1) ? nb : 4); j++) b.push_back(wv[8*j +: 8]);
            end
            while (b.size() < MIN_BYTES) b.push_back(8'h00);
            fcs = ~crc32_bytes(b);
            for (int j = 0; j < 4; j++) b.push_back(fcs[8*j +: 8]);
            for (int i = 0; i < b.size(); i++) begin
                v = b[i];
                exp_q.push_back({v[3:0], 3'b000});
                exp_q.push_back({v[7:4], 1'b0, (i == b.size() - 1), 1'b0});
            end
            len_q.push_back(PRE + 1 + 2 * b.size());
            gap_q.push_back(IFG);
        end
    endtask

    task automatic wait_hs(input bit need_valid);
        bit hs;
        int k;
        for (k = 0; k < 4000; k++) begin
            @(negedge clk);
            hs = axis.s_tready && (axis.s_tvalid || !need_valid);
            @(posedge clk);
            if (hs) break;
        end
        if (k == 4000) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no tready expected tready within 4000 cycles");
        end
    endtask

    task automatic send_frame(input logic [31:0] w[$], input logic [3:0] kp, input int miss);
        int n;
        n = w.size();
        push_frame(w, kp, miss);
        for (int i = 0; i < n; i++) begin
            if (i == miss) begin
                axis.s_tvalid = 1'b0;
                wait_hs(1'b0);
                #1;
            end
            axis.s_tdata  = w[i];
            axis.s_tkeep  = (i == n - 1) ? kp : 4'($urandom_range(0, 15));
            axis.s_tlast  = (i == n - 1);
            axis.s_tvalid = 1'b1;
            wait_hs(1'b1);
            #1;
        end
    endtask

    // Monitor: pops one expected nibble per tx_en cycle, checks frame lengths and gaps.
    int run_len = 0;
    int gap_len = 0;
    bit prev_en = 1'b0;
    bit seen    = 1'b0;
    always @(negedge clk) begin
        logic [6:0] e;
        int         g;
        if (mon_en) begin
            if (phy_tx_en) begin
                if (!prev_en) begin
                    if (seen) begin
                        if (gap_q.size() == 0) check("ifg_gap_unexpected", 32'(gap_len), 32'hFFFFFFFF);
                        else begin
                            g = gap_q.pop_front();
                            check("ifg_gap", 32'(gap_len), 32'(g));
                        end
                    end
                    run_len = 0;
                end
                run_len++;
                if (exp_q.size() == 0) begin
                    check("unexpected_nibble", {25'd0, phy_txd, phy_tx_er, tx_frame_done, tx_underrun}, 32'hFFFFFFFF);
                end else begin
                    e = exp_q.pop_front();
                    check("nibble", {24'd0, phy_txd, phy_tx_er, tx_frame_done, tx_underrun, tx_busy},
                          {24'd0, e, 1'b1});
                end
            end else begin
                if (prev_en) begin
                    seen    = 1'b1;
                    gap_len = 0;
                    if (len_q.size() == 0) check("frame_len_unexpected", 32'(run_len), 32'hFFFFFFFF);
                    else begin
                        g = len_q.pop_front();
                        check("frame_len", 32'(run_len), 32'(g));
                    end
                end
                gap_len++;
                check("idle_flags", {29'd0, phy_tx_er, tx_frame_done, tx_underrun}, 32'd0);
            end
            prev_en = phy_tx_en;
        end
    end

    initial begin
        logic [31:0] w[$];
        logic [31:0] dv;
        logic [3:0]  kps[5];
        int          n, miss, k;

        kps = '{4'h1, 4'h3, 4'h7, 4'hF, 4'h0};
        axis.s_tdata  = 32'd0;
        axis.s_tkeep  = 4'h0;
        axis.s_tlast  = 1'b0;
        axis.s_tvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_state", {22'd0, phy_txd, phy_tx_en, phy_tx_er, tx_busy, tx_frame_done, tx_underrun, axis.s_tready}, 32'd0);

        // Preamble latency, first data nibbles, then reset in the middle of the word.
        dv = 32'hDEADBEEF;
        axis.s_tdata  = dv;
        axis.s_tkeep  = 4'hF;
        axis.s_tvalid = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk);
            #1;
            check("preamble", {26'd0, phy_txd, phy_tx_en, axis.s_tready},
                  (c < 16) ? {26'd0, 4'h5, 1'b1, 1'b0} : {26'd0, 4'hD, 1'b1, 1'b1});
        end
        @(posedge clk);
        #1;
        axis.s_tvalid = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            check("data_nibble", {27'd0, phy_txd, phy_tx_en}, {27'd0, dv[4*c +: 4], 1'b1});
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("reset_mid_frame", {22'd0, phy_txd, phy_tx_en, phy_tx_er, tx_busy, tx_frame_done, tx_underrun, axis.s_tready}, 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;

        w = '{32'h34333231, 32'h38373635, 32'h00000039};
        send_frame(w, 4'h1, -1);
        w = '{32'hDEADBEEF};
        send_frame(w, 4'hF, -1);
        w = '{32'h11223344, 32'h55667788};
        send_frame(w, 4'hF, 1);
        for (int f = 0; f < 10; f++) begin
            n = $urandom_range(1, 18);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            miss = (n >= 2 && $urandom_range(0, 3) == 0) ? $urandom_range(1, n - 1) : -1;
            send_frame(w, kps[$urandom_range(0, 4)], miss);
        end
        axis.s_tvalid = 1'b0;

        for (k = 0; k < 20000 && exp_q.size() != 0; k++) @(posedge clk);
        check("all_nibbles_seen", 32'(exp_q.size()), 32'd0);
        repeat (IFG + 6) @(posedge clk);
        #1;
        check("idle_after_ifg", {30'd0, tx_busy, phy_tx_en}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
